// File: rtl/seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : seq_pkg                                                    |
// | Shared state encoding and default code width for the period monitor. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package seq_pkg;

  localparam int SEQ_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DONE    = 2'd2
  } seq_state_e;

endpackage : seq_pkg
`default_nettype wire

// File: rtl/seq_stuck_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : seq_stuck_detect                                           |
// | Sticky flag raised when two consecutive samples carry the same code. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module seq_stuck_detect
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             restart,
  input  logic             en,
  input  logic [WIDTH-1:0] q_in,
  output logic             stuck
);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic             stuck_q, stuck_d;

  // A restart forgets the history, so the first sample after it cannot flag.
  always_comb begin
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    stuck_d     = stuck_q;
    if (restart) begin
      have_prev_d = 1'b0;
      stuck_d     = 1'b0;
    end else if (en) begin
      if (have_prev_q && (q_in == prev_q)) begin
        stuck_d = 1'b1;
      end
      prev_d      = q_in;
      have_prev_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      stuck_q     <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      stuck_q     <= stuck_d;
    end
  end

  assign stuck = stuck_q;

endmodule : seq_stuck_detect
`default_nettype wire

// File: rtl/seq_period_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : seq_period_monitor                                         |
// | Measures the cycle length of an upstream sequence counter.           |
// | Optional macro SEQ_VISITED_EN adds the visited-code bitmap output.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module seq_period_monitor
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  en,
  input  logic [WIDTH-1:0]      q_in,
  input  logic                  restart,
  output logic [WIDTH:0]        period,
  output logic                  period_valid,
  output logic                  overflow,
  output logic                  stuck,
  output logic                  busy
`ifdef SEQ_VISITED_EN
  ,
  output logic [2**WIDTH-1:0]   visited
`endif
);

  localparam int             DEPTH   = 2**WIDTH;
  localparam logic [WIDTH:0] CNT_ONE = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] CNT_MAX = {1'b1, {WIDTH{1'b0}}};

  seq_state_e       state_q, state_d;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH:0]   period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             overflow_q, overflow_d;
  logic             take_sample;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ref_d          = ref_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    overflow_d     = overflow_q;
    take_sample    = 1'b0;
    if (restart) begin
      state_d        = ST_IDLE;
      cnt_d          = '0;
      period_d       = '0;
      period_valid_d = 1'b0;
      overflow_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            ref_d       = q_in;
            cnt_d       = CNT_ONE;
            take_sample = 1'b1;
            state_d     = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (en) begin
            take_sample = 1'b1;
            if (q_in == ref_q) begin
              period_d       = cnt_q;
              period_valid_d = 1'b1;
              state_d        = ST_DONE;
            end else if (cnt_q == CNT_MAX) begin
              period_d   = '0;
              overflow_d = 1'b1;
              state_d    = ST_DONE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      ref_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ref_q          <= ref_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      overflow_q     <= overflow_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q == ST_MEASURE);

  seq_stuck_detect #(
    .WIDTH (WIDTH)
  ) u_stuck (
    .clk     (clk),
    .clear   (clear),
    .restart (restart),
    .en      (en),
    .q_in    (q_in),
    .stuck   (stuck)
  );

`ifdef SEQ_VISITED_EN
  logic [DEPTH-1:0] visited_q, visited_d;

  // Sampling is already gated to IDLE-capture and MEASURE, so DONE freezes it.
  always_comb begin
    visited_d = visited_q;
    if (restart) begin
      visited_d = '0;
    end else if (take_sample) begin
      visited_d[q_in] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      visited_q <= '0;
    end else begin
      visited_q <= visited_d;
    end
  end

  assign visited = visited_q;
`else
  logic unused_sample;
  assign unused_sample = take_sample;
`endif

endmodule : seq_period_monitor
`default_nettype wire

// File: tb/tb_seq_period_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_seq_period_monitor                                      |
// | Random and directed checks against a queue-based reference model.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_seq_period_monitor;

  localparam int W     = 4;
  localparam int DEPTH = 2**W;

  logic           clk = 1'b0;
  logic           clear = 1'b0;
  logic           en = 1'b0;
  logic [W-1:0]   q_in = '0;
  logic           restart = 1'b0;
  logic [W:0]     period;
  logic           period_valid;
  logic           overflow;
  logic           stuck;
  logic           busy;
`ifdef SEQ_VISITED_EN
  logic [DEPTH-1:0] visited;
`endif

  seq_period_monitor #(.WIDTH(W)) dut (
    .clk          (clk),
    .clear        (clear),
    .en           (en),
    .q_in         (q_in),
    .restart      (restart),
    .period       (period),
    .period_valid (period_valid),
    .overflow     (overflow),
    .stuck        (stuck),
    .busy         (busy)
`ifdef SEQ_VISITED_EN
    ,
    .visited      (visited)
`endif
  );

  always #5 clk = ~clk;

  int vectors   = 0;
  int miscomp   = 0;
  bit checking  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscomp++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: samples of the running measurement kept in a queue.
  logic [W-1:0]     meas[$];
  int               m_phase = 0;   // 0 waiting for capture, 1 measuring, 2 finished
  int               m_period = 0;
  bit               m_valid = 0, m_ovf = 0, m_stuck = 0, have_prev = 0;
  logic [W-1:0]     prev = '0;
  logic [DEPTH-1:0] m_vis = '0;

  always @(posedge clk) begin
    if (clear || restart) begin
      meas.delete();
      m_phase = 0; m_period = 0; m_valid = 0; m_ovf = 0;
      m_stuck = 0; have_prev = 0; m_vis = '0;
    end else if (en) begin
      if (have_prev && q_in == prev) m_stuck = 1;
      prev = q_in;
      have_prev = 1;
      if (m_phase == 0) begin
        meas.push_back(q_in);
        m_vis[q_in] = 1'b1;
        m_phase = 1;
      end else if (m_phase == 1) begin
        m_vis[q_in] = 1'b1;
        if (q_in == meas[0]) begin
          m_period = meas.size();
          m_valid = 1;
          m_phase = 2;
        end else if (meas.size() == DEPTH) begin
          m_period = 0;
          m_ovf = 1;
          m_phase = 2;
        end else begin
          meas.push_back(q_in);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("period", int'(period), m_period);
      chk("period_valid", int'(period_valid), int'(m_valid));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("stuck", int'(stuck), int'(m_stuck));
      chk("busy", int'(busy), int'(m_phase == 1));
`ifdef SEQ_VISITED_EN
      chk("visited", int'(visited), int'(m_vis));
`endif
    end
  end

  task automatic step(input bit e, input int q, input bit rs = 1'b0, input bit cl = 1'b0);
    @(negedge clk);
    #1;
    en = e; q_in = W'(q); restart = rs; clear = cl;
    @(posedge clk);
    #1;
    en = 1'b0; restart = 1'b0; clear = 1'b0;
  endtask

  task automatic seq(input int codes[]);
    foreach (codes[i]) step(1'b1, codes[i]);
  endtask

  initial begin
    int r;
    step(1'b0, 0, 1'b0, 1'b1);
    checking = 1'b1;
    chk("reset_period", int'(period), 0);
    chk("reset_valid", int'(period_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_stuck", int'(stuck), 0);

    seq('{3, 7, 10, 3});
    chk("p3_period", int'(period), 3);
    chk("p3_valid", int'(period_valid), 1);
    chk("p3_busy", int'(busy), 0);
`ifdef SEQ_VISITED_EN
    chk("p3_visited", int'(visited), 32'h0488);
`endif

    step(1'b0, 0, 1'b1);
    seq('{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 1});
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_period", int'(period), 0);
    chk("ovf_valid", int'(period_valid), 0);

    step(1'b0, 0, 1'b1);
    seq('{5, 5});
    chk("stuck_set", int'(stuck), 1);
    seq('{6, 7, 8});
    chk("stuck_sticky", int'(stuck), 1);
    step(1'b0, 0, 1'b1);
    chk("stuck_cleared", int'(stuck), 0);

    seq('{2, 9});
    repeat (4) step(1'b0, 2);
    step(1'b1, 2);
    chk("pause_period", int'(period), 2);
    chk("pause_valid", int'(period_valid), 1);

    step(1'b0, 0, 1'b1);
    seq('{4, 6});
    step(1'b1, 4, 1'b1);
    chk("rs_pri_valid", int'(period_valid), 0);
    chk("rs_pri_busy", int'(busy), 0);

    seq('{4, 6});
    chk("mid_busy", int'(busy), 1);
    step(1'b1, 4, 1'b1, 1'b1);
    chk("clr_period", int'(period), 0);
    chk("clr_valid", int'(period_valid), 0);
    chk("clr_busy", int'(busy), 0);
    chk("clr_ovf", int'(overflow), 0);

    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, DEPTH - 1)),
           r < 4, r == 99);
    end

    @(negedge clk);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
    $finish;
  end

endmodule : tb_seq_period_monitor
`default_nettype wire
